// File: rtl/rx_frame_checker.sv
// Frame checker behind DataReceiver: CRC-8 verify, buffer good payloads, count drops.
// Latency: 27 cycles from receive_done edge to pl_valid (FIFO empty case).
// Backpressure: pl_valid/pl_ready handshake; frames arriving while busy or into a full FIFO are dropped and counted.

// Small synchronous FIFO with registered storage and occupancy-driven full/empty.
// Latency: 1 cycle push-to-valid; head read straight from storage.
// Backpressure: in_rdy low only when full and no pop this cycle.
module rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;

    assign out_vld = (cnt_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign pop     = out_vld && out_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign in_rdy  = (cnt_q != (AW+1)'(DEPTH)) || pop;
    assign push    = in_vld && in_rdy;

    // Storage, pointers and occupancy; push and pop may both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module rx_frame_checker #(
    parameter int DATA_W = 216,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              receive_done,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-9:0] pl_data,
    output logic              pl_valid,
    input  logic              pl_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  crc_err_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);
    localparam int NBYTES = (DATA_W - 8) / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  frame_q, frame_d;
    logic [7:0]         crc_q, crc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   crc_err_q, crc_err_d;
    logic [CNT_W-1:0]   overrun_q, overrun_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;
    logic               push_vld, fifo_in_rdy;
    logic [7:0]         pl_bytes [NBYTES];

    // CRC-8 poly 0x07, MSB-first, whole byte folded in per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Byte 0 is the most significant payload byte.
    for (genvar b = 0; b < NBYTES; b++) begin : g_bytes
        assign pl_bytes[b] = frame_q[DATA_W-1-8*b -: 8];
    end

    // State, capture, CRC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            crc_q     <= '0;
            idx_q     <= '0;
            crc_err_q <= '0;
            overrun_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            crc_err_q <= crc_err_d;
            overrun_q <= overrun_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state: capture in IDLE, one payload byte per CHECK cycle, verdict in DONE.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        crc_err_d = crc_err_q;
        overrun_d = overrun_q;
        ovf_d     = ovf_q;
        push_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (receive_done) begin
                    frame_d = data_out;
                    crc_d   = '0;
                    idx_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                crc_d = crc8_byte(crc_q, pl_bytes[idx_q]);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NBYTES - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (crc_q == frame_q[7:0]) begin
                    push_vld = 1'b1;
                    if (!fifo_in_rdy) ovf_d = sat_inc(ovf_q);
                end else begin
                    crc_err_d = sat_inc(crc_err_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // A frame landing mid-check is lost; the frame in flight is untouched.
        if (receive_done && state_q != IDLE) overrun_d = sat_inc(overrun_q);
    end

    rx_fifo #(.W(DATA_W - 8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push_vld),
        .in_dat  (frame_q[DATA_W-1:8]),
        .in_rdy  (fifo_in_rdy),
        .out_vld (pl_valid),
        .out_dat (pl_data),
        .out_rdy (pl_ready)
    );

    assign busy        = (state_q != IDLE);
    assign crc_err_cnt = crc_err_q;
    assign overrun_cnt = overrun_q;
    assign ovf_cnt     = ovf_q;
endmodule

// File: tb/tb_rx_frame_checker.sv
// Testbench for rx_frame_checker: directed frames, scoreboard queue for payloads.
// Latency: checks pl_valid timing at 27 cycles after capture.
// Backpressure: exercises pl_ready low/high, FIFO full and push-with-pop.
module tb_rx_frame_checker;
    logic         clk;
    logic         rst;
    logic         receive_done;
    logic [215:0] data_out;
    logic [207:0] pl_data;
    logic         pl_valid;
    logic         pl_ready;
    logic         busy;
    logic [7:0]   crc_err_cnt, overrun_cnt, ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [207:0] exp_q [$];

    rx_frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .receive_done (receive_done),
        .data_out     (data_out),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .busy         (busy),
        .crc_err_cnt  (crc_err_cnt),
        .overrun_cnt  (overrun_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [215:0] mk(input logic [7:0] last, input logic [7:0] crc);
        return {200'd0, last, crc};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle receive_done; returns one time unit after the capture edge.
    task automatic send(input logic [215:0] f);
        receive_done = 1'b1;
        data_out     = f;
        tick(1);
        receive_done = 1'b0;
        data_out     = '0;
    endtask

    // Monitor: every accepted head must match the oldest expected payload.
    always @(negedge clk) begin
        if (!rst && pl_valid && pl_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", pl_data, '1);
            end else begin
                chk("pl_data", pl_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst          = 1'b1;
        receive_done = 1'b0;
        data_out     = '0;
        pl_ready     = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("rst_pl_valid", 208'(pl_valid), 208'd0);
        chk("rst_pl_data", pl_data, 208'd0);
        chk("rst_busy", 208'(busy), 208'd0);
        chk("rst_crc_err", 208'(crc_err_cnt), 208'd0);
        chk("rst_overrun", 208'(overrun_cnt), 208'd0);
        chk("rst_ovf", 208'(ovf_cnt), 208'd0);

        // All-zero frame: exact timing of a single-cycle pl_valid
        pl_ready = 1'b1;
        exp_q.push_back(208'd0);
        send(mk(8'h00, 8'h00));
        tick(26);
        chk("zero_valid_e26", 208'(pl_valid), 208'd0);
        chk("zero_busy_e26", 208'(busy), 208'd1);
        tick(1);
        chk("zero_valid_e27", 208'(pl_valid), 208'd1);
        chk("zero_busy_e27", 208'(busy), 208'd0);
        tick(1);
        chk("zero_valid_e28", 208'(pl_valid), 208'd0);
        chk("zero_crc_err", 208'(crc_err_cnt), 208'd0);

        // Last byte 0x01: good CRC 0x07, bad CRC 0x06
        exp_q.push_back(208'h01);
        send(mk(8'h01, 8'h07));
        tick(30);
        send(mk(8'h01, 8'h06));
        tick(30);
        chk("bad_crc_err", 208'(crc_err_cnt), 208'd1);
        chk("bad_no_valid", 208'(pl_valid), 208'd0);

        // Three good frames with consumer stalled: third overflows
        pl_ready = 1'b0;
        exp_q.push_back(208'h01);
        exp_q.push_back(208'h02);
        send(mk(8'h01, 8'h07));
        tick(29);
        send(mk(8'h02, 8'h0E));
        tick(29);
        send(mk(8'h03, 8'h09));
        tick(29);
        chk("full_ovf", 208'(ovf_cnt), 208'd1);
        chk("full_valid", 208'(pl_valid), 208'd1);
        chk("full_head", pl_data, 208'h01);
        pl_ready = 1'b1;
        tick(3);
        chk("drain_valid", 208'(pl_valid), 208'd0);

        // Overrun: second receive_done 10 cycles after the first
        exp_q.push_back(208'h01);
        send(mk(8'h01, 8'h07));
        tick(9);
        send(mk(8'h02, 8'h0E));
        tick(16);
        chk("ovr_busy_e26", 208'(busy), 208'd1);
        tick(1);
        chk("ovr_busy_e27", 208'(busy), 208'd0);
        chk("ovr_valid_e27", 208'(pl_valid), 208'd1);
        chk("ovr_cnt", 208'(overrun_cnt), 208'd1);
        tick(3);

        // Full FIFO, good frame reaches DONE while the head is popped
        pl_ready = 1'b0;
        exp_q.push_back(208'h01);
        exp_q.push_back(208'h02);
        exp_q.push_back(208'h03);
        send(mk(8'h01, 8'h07));
        tick(29);
        send(mk(8'h02, 8'h0E));
        tick(29);
        send(mk(8'h03, 8'h09));
        tick(26);
        pl_ready = 1'b1;
        tick(1);
        chk("pp_ovf", 208'(ovf_cnt), 208'd1);
        chk("pp_valid", 208'(pl_valid), 208'd1);
        chk("pp_head", pl_data, 208'h02);
        tick(4);
        chk("pp_drained", 208'(pl_valid), 208'd0);

        // Reset mid-CHECK discards the frame in flight
        send(mk(8'h01, 8'h07));
        tick(12);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 208'(busy), 208'd0);
        chk("mid_rst_valid", 208'(pl_valid), 208'd0);
        chk("mid_rst_ovf", 208'(ovf_cnt), 208'd0);
        chk("mid_rst_ovr", 208'(overrun_cnt), 208'd0);
        chk("mid_rst_crc", 208'(crc_err_cnt), 208'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        exp_q.push_back(208'h02);
        send(mk(8'h02, 8'h0E));
        tick(26);
        tick(1);
        chk("post_rst_valid", 208'(pl_valid), 208'd1);
        tick(3);

        // 300 corrupt frames: counter saturates
        for (int i = 0; i < 300; i++) begin
            send(mk(8'h01, 8'h06));
            tick(28);
            if (i == 253) chk("crc_cnt_254", 208'(crc_err_cnt), 208'd254);
        end
        chk("crc_cnt_sat", 208'(crc_err_cnt), 208'd255);
        chk("sat_no_valid", 208'(pl_valid), 208'd0);
        chk("sb_empty", 208'(exp_q.size()), 208'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
